// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
// Optional first-word-fall-through read mode is selected by macro PARAM_FIFO_FWFT_EN.
package param_fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Address width needed to index DEPTH entries (log2 of a power-of-two depth).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// FIFO storage array: DEPTH x WIDTH, one synchronous write port, one
// asynchronous read port. Contents are never reset.
module param_fifo_mem
   import param_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Store the accepted word at the write address.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: pointer/count control, status flags and
// overflow/underflow pulses; storage lives in param_fifo_mem.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; otherwise
// rd_data is registered and updates on the edge that accepts a read.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   // Reject illegal configurations at elaboration time.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("param_fifo: DEPTH must be a power of two and at least 2");
      end
      if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
         $error("param_fifo: AE_LEVEL must be below AF_LEVEL");
      end
   endgenerate

   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             wr_accept;
   logic             rd_accept;
   logic [WIDTH-1:0] head_data;

   // Flags come straight from the registered occupancy.
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // At full a simultaneous read frees nothing this cycle, so the write is
   // still rejected; symmetrically at empty the read is rejected.
   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   // Occupancy moves only when exactly one side is accepted.
   always_comb begin
      count_next = count_reg;
      case ({wr_accept, rd_accept})
         2'b10:   count_next = count_reg + ONE_C;
         2'b01:   count_next = count_reg - ONE_C;
         default: count_next = count_reg;
      endcase
   end

   // Pointer, occupancy and error-pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_accept) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg     <= count_next;
         overflow_reg  <= wr_en && full;
         underflow_reg <= rd_en && empty;
      end
   end

   param_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr_reg),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_reg),
      .rd_data (head_data)
   );

`ifdef PARAM_FIFO_FWFT_EN
   // Head word is visible whenever the FIFO holds data; rd_en only pops.
   assign rd_data = head_data;
`else
   logic [WIDTH-1:0] rd_data_reg;

   // Capture the head word on the edge that accepts a read, hold otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_reg <= '0;
      end else if (rd_accept) begin
         rd_data_reg <= head_data;
      end
   end

   assign rd_data = rd_data_reg;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (WIDTH=8, DEPTH=8, AF=7, AE=1).
// A queue-based model is compared every cycle; directed steps add literal checks.
module tb_param_fifo;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 8;
   localparam int AF_LEVEL = 7;
   localparam int AE_LEVEL = 1;
   localparam int CW       = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] rd_data;
   logic             full, empty, almost_full, almost_empty;
   logic [CW-1:0]    count;
   logic             overflow, underflow;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   param_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of stored words plus last-read word and pulses.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_rd  = '0;
   bit               m_ovf = 1'b0;
   bit               m_unf = 1'b0;

   always @(posedge clk or negedge reset) begin : model
      int  n;
      bit  do_wr, do_rd;
      if (!reset) begin
         q.delete();
         m_rd  = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         n     = q.size();
         m_ovf = wr_en && (n == DEPTH);
         m_unf = rd_en && (n == 0);
         do_wr = wr_en && (n != DEPTH);
         do_rd = rd_en && (n != 0);
         if (do_rd) m_rd = q.pop_front();
         if (do_wr) q.push_back(wr_data);
      end
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_count",  32'(count),        32'(q.size()));
         check("cmp_full",   32'(full),         32'(q.size() == DEPTH));
         check("cmp_empty",  32'(empty),        32'(q.size() == 0));
         check("cmp_afull",  32'(almost_full),  32'(q.size() >= AF_LEVEL));
         check("cmp_aempty", 32'(almost_empty), 32'(q.size() <= AE_LEVEL));
         check("cmp_ovf",    32'(overflow),     32'(m_ovf));
         check("cmp_unf",    32'(underflow),    32'(m_unf));
`ifdef PARAM_FIFO_FWFT_EN
         if (q.size() != 0) check("cmp_rd_data", 32'(rd_data), 32'(q[0]));
`else
         check("cmp_rd_data", 32'(rd_data), 32'(m_rd));
`endif
      end
   end

   // One clock of stimulus; returns 1 time unit after the rising edge.
   task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      $display("step t=%0t we=%0b wd=%02h re=%0b -> count=%0d rd_data=%02h ovf=%0b unf=%0b",
               $time, we, wd, re, count, rd_data, overflow, underflow);
   endtask

   // Pop one word (optionally writing too) and check the word read out.
   task automatic pop_check(input logic we, input logic [WIDTH-1:0] wd,
                            input string name, input logic [WIDTH-1:0] exp);
`ifdef PARAM_FIFO_FWFT_EN
      check(name, 32'(rd_data), 32'(exp));
      step(we, wd, 1'b1);
`else
      step(we, wd, 1'b1);
      check(name, 32'(rd_data), 32'(exp));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      check("rst_count",  32'(count), 32'd0);
      check("rst_empty",  32'(empty), 32'd1);
      check("rst_aempty", 32'(almost_empty), 32'd1);
      check("rst_full",   32'(full), 32'd0);
      check("rst_afull",  32'(almost_full), 32'd0);
`ifndef PARAM_FIFO_FWFT_EN
      check("rst_rd_data", 32'(rd_data), 32'd0);
`endif
      reset = 1'b1;

      // Fill with 0x01..0x08, then one rejected write.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 8'(i), 1'b0);
         if (i == 7) begin
            check("fill7_afull", 32'(almost_full), 32'd1);
            check("fill7_full",  32'(full), 32'd0);
         end
      end
      check("fill8_full",  32'(full), 32'd1);
      check("fill8_count", 32'(count), 32'd8);
      step(1'b1, 8'hAA, 1'b0);
      check("ovf_pulse", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      step(1'b0, 8'h00, 1'b0);
      check("ovf_clear", 32'(overflow), 32'd0);

      // Drain in order, then one rejected read.
      for (int i = 1; i <= 8; i++) begin
         pop_check(1'b0, 8'h00, "drain_data", 8'(i));
      end
      step(1'b0, 8'h00, 1'b1);
      check("unf_pulse", 32'(underflow), 32'd1);
      check("unf_empty", 32'(empty), 32'd1);
`ifndef PARAM_FIFO_FWFT_EN
      check("unf_hold", 32'(rd_data), 32'h08);
`endif
      step(1'b0, 8'h00, 1'b0);
      check("unf_clear", 32'(underflow), 32'd0);

      // Simultaneous read/write at full: write rejected.
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      step(1'b1, 8'h55, 1'b1);
      check("both_full_ovf",   32'(overflow), 32'd1);
      check("both_full_count", 32'(count), 32'd7);
      for (int i = 1; i <= 7; i++) pop_check(1'b0, 8'h00, "both_full_data", 8'(8'h10 + i));
      check("both_full_nostore", 32'(count), 32'd0);

      // Simultaneous read/write at empty: read rejected.
      step(1'b1, 8'h55, 1'b1);
      check("both_empty_unf",   32'(underflow), 32'd1);
      check("both_empty_count", 32'(count), 32'd1);
      pop_check(1'b0, 8'h00, "both_empty_data", 8'h55);

      // Streaming with occupancy held at 3; pointers wrap more than twice.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
      for (int k = 0; k < 20; k++) begin
         pop_check(1'b1, 8'(8'h70 + k), "stream_data",
                   (k < 3) ? 8'(8'h60 + k) : 8'(8'h70 + k - 3));
         check("stream_count", 32'(count), 32'd3);
      end
      for (int k = 17; k < 20; k++) pop_check(1'b0, 8'h00, "stream_tail", 8'(8'h70 + k));
      check("stream_empty", 32'(empty), 32'd1);

      // Asynchronous reset mid-traffic with five words stored.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      check("pre_rst_count", 32'(count), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_empty", 32'(empty), 32'd1);
      check("arst_full",  32'(full), 32'd0);
`ifndef PARAM_FIFO_FWFT_EN
      check("arst_rd_data", 32'(rd_data), 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Resume after reset with a single word.
      step(1'b1, 8'h3C, 1'b0);
      check("resume_count", 32'(count), 32'd1);
`ifdef PARAM_FIFO_FWFT_EN
      check("fwft_data", 32'(rd_data), 32'h3C);
      step(1'b0, 8'h00, 1'b1);
`else
      step(1'b0, 8'h00, 1'b1);
      check("resume_data", 32'(rd_data), 32'h3C);
`endif
      check("resume_empty", 32'(empty), 32'd1);

      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
